// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the SRAM arbiter slice.
//   - state_t : access sequencer states (IDLE -> ACC -> DONE -> IDLE)
//   - port_t  : requester identity (PORT_A = CPU/Mem2IO, PORT_B = video fetch)
//   - req_t   : one latched access (we, addr, be, wdata)
//   - CYC_W   : width of the in-access cycle counter (covers timings up to 7)
//   - WAIT_W  : width of the starvation counter (covers MAX_WAIT up to 15)
//   The SRAM geometry is fixed here; req_t is built from these widths.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int CYC_W       = 3;
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [1:0]             be;
        logic [SRAM_DATA_W-1:0] wdata;
    } req_t;

    // Index of the final ACC cycle for a read or a write.
    function automatic logic [CYC_W-1:0] last_cyc(input logic we,
                                                  input int   rd_cyc,
                                                  input int   wr_cyc);
        return we ? CYC_W'(wr_cyc - 1) : CYC_W'(rd_cyc - 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles both requester ports and the SRAM pin-side bus.
//   Requester port X (X = a, b):
//     x_req, x_we, x_addr, x_be, x_wdata  requester -> arbiter
//     x_ack (one-cycle pulse), x_rdata    arbiter   -> requester
//   SRAM side:
//     sram_addr, sram_*_n strobes, sram_dq_out, sram_dq_oe  arbiter -> pins
//     sram_dq_in                                            pins    -> arbiter
//   Modports: slave = arbiter view, master = environment (requesters + SRAM).
// -----------------------------------------------------------------------------
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [1:0]        a_be;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [1:0]        b_be;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_ub_n;
    logic              sram_lb_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;

    modport slave (
        input  a_req, a_we, a_addr, a_be, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_be, b_wdata,
        output b_ack, b_rdata,
        output sram_addr, sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n,
        output sram_dq_out, sram_dq_oe,
        input  sram_dq_in
    );

    modport master (
        output a_req, a_we, a_addr, a_be, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_be, b_wdata,
        input  b_ack, b_rdata,
        input  sram_addr, sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n,
        input  sram_dq_out, sram_dq_oe,
        output sram_dq_in
    );

endinterface

// File: rtl/sram_arb_grant.sv
// -----------------------------------------------------------------------------
// sram_arb_grant
//   Grant decision for the two requesters plus the starvation counter.
//   Port B (video) wins ties until it has taken MAX_WAIT consecutive grants
//   while A was waiting; then A is forced through once.
//   Ports:
//     Clk, Reset     clock, synchronous active-low reset
//     a_req, b_req   raw requests
//     in_idle        sequencer is in IDLE and may accept a grant
//     grant_valid    a grant is made this cycle
//     grant_id       which port is granted (meaningful with grant_valid)
// -----------------------------------------------------------------------------
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  a_req,
    input  logic  b_req,
    input  logic  in_idle,
    output logic  grant_valid,
    output port_t grant_id
);

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_full;

    assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant_valid = in_idle && (a_req || b_req);
        grant_id    = PORT_B;
        if (a_req && (!b_req || wait_full)) begin
            grant_id = PORT_A;
        end
    end

    // Counts B grants taken while A was left waiting; any A grant restarts it.
    always_ff @(posedge Clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (grant_valid) begin
            if (grant_id == PORT_A) begin
                wait_cnt <= '0;
            end else if (a_req && !wait_full) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Sequences every access to a single shared 16-bit asynchronous SRAM on
//   behalf of two requesters (A = CPU/Mem2IO, B = video fetch, B has priority
//   subject to a starvation limit for A).
//   Access timing:
//     read : RD_CYC cycles with CE/OE low, data sampled on the last ACC edge
//     write: WR_CYC cycles, cycle 0 is address setup (WE high), WE low after
//     DONE : one cycle, strobes released, ack to the granted port; for writes
//            the data bus stays driven for hold after WE rises.
//   Ports:
//     Clk, Reset  clock, synchronous active-low reset
//     bus         sram_arbiter_if.slave: both requester ports and SRAM pins
//   All SRAM outputs are decoded from registered state only; request inputs
//   never reach the pins combinationally.
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int RD_CYC   = 2,
    parameter int WR_CYC   = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    sram_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [CYC_W-1:0]  cyc;
    logic [CYC_W-1:0]  cyc_nxt;
    logic [CYC_W-1:0]  cyc_last;
    port_t             port_q;
    req_t              req_q;
    req_t              a_fields;
    req_t              b_fields;
    logic              grant_valid;
    port_t             grant_id;
    logic              rd_sample;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Decoded pin-side values, driven onto the interface below.
    logic              ce_n;
    logic              ub_n;
    logic              lb_n;
    logic              oe_n;
    logic              we_n;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_out;
    logic [ADDR_W-1:0] addr;
    logic              a_ack;
    logic              b_ack;

    assign a_fields = '{we: bus.a_we, addr: bus.a_addr, be: bus.a_be, wdata: bus.a_wdata};
    assign b_fields = '{we: bus.b_we, addr: bus.b_addr, be: bus.b_be, wdata: bus.b_wdata};

    sram_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .Clk         (Clk),
        .Reset       (Reset),
        .a_req       (bus.a_req),
        .b_req       (bus.b_req),
        .in_idle     (state == IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign cyc_last  = last_cyc(req_q.we, RD_CYC, WR_CYC);
    assign rd_sample = (state == ACC) && !req_q.we && (cyc == cyc_last);

    // State, cycle counter, latched access and per-port read data.
    // The latched access is reset too: it feeds dq_out and addr decoding.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            cyc       <= '0;
            port_q    <= PORT_A;
            req_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            if (grant_valid) begin
                port_q <= grant_id;
                req_q  <= (grant_id == PORT_A) ? a_fields : b_fields;
            end
            // Only the granted port's read data moves; the other holds.
            if (rd_sample) begin
                if (port_q == PORT_A) begin
                    a_rdata_q <= bus.sram_dq_in;
                end else begin
                    b_rdata_q <= bus.sram_dq_in;
                end
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        ce_n      = 1'b1;
        ub_n      = 1'b1;
        lb_n      = 1'b1;
        oe_n      = 1'b1;
        we_n      = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        addr      = '0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = ACC;
                    cyc_nxt   = '0;
                end
            end

            ACC: begin
                ce_n = 1'b0;
                ub_n = ~req_q.be[1];
                lb_n = ~req_q.be[0];
                addr = req_q.addr;
                if (req_q.we) begin
                    dq_oe  = 1'b1;
                    dq_out = req_q.wdata;
                    // Cycle 0 is address setup; WE falls only afterwards.
                    we_n   = (cyc == '0);
                end else begin
                    oe_n = 1'b0;
                end
                if (cyc == cyc_last) begin
                    state_nxt = DONE;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc + CYC_W'(1);
                end
            end

            DONE: begin
                addr = req_q.addr;
                // Keep write data on the bus one cycle past the WE rising edge.
                if (req_q.we) begin
                    dq_oe  = 1'b1;
                    dq_out = req_q.wdata;
                end
                a_ack     = (port_q == PORT_A);
                b_ack     = (port_q == PORT_B);
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.sram_addr   = addr;
    assign bus.sram_ce_n   = ce_n;
    assign bus.sram_ub_n   = ub_n;
    assign bus.sram_lb_n   = lb_n;
    assign bus.sram_oe_n   = oe_n;
    assign bus.sram_we_n   = we_n;
    assign bus.sram_dq_oe  = dq_oe;
    assign bus.sram_dq_out = dq_out;
    assign bus.a_ack       = a_ack;
    assign bus.b_ack       = b_ack;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter with RD_CYC = WR_CYC = 2 (N = 2) and
//   MAX_WAIT = 3. A small byte-lane SRAM model (256 words, indexed by the low
//   address byte) answers reads and commits writes. Expected values are
//   hand-computed from the access timing: ack N+1 cycles after the request is
//   seen in IDLE, back-to-back grants N+2 cycles apart.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sram_arbiter_if bus ();

    sram_arbiter #(
        .ADDR_W   (20),
        .DATA_W   (16),
        .RD_CYC   (2),
        .WR_CYC   (2),
        .MAX_WAIT (3)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int cyc_cnt = 0;
    int passed  = 0;
    int total   = 0;
    int failed  = 0;

    always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- SRAM model ----------------
    logic [15:0] mem [256];

    always @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h01] <= 16'h1111;
            mem[8'h02] <= 16'h2222;
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'h5A5A;
            mem[8'h21] <= 16'hC3C3;
            mem[8'h40] <= 16'h4444;
            mem[8'hFF] <= 16'hABCD;
        end else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            if (!bus.sram_ub_n) mem[bus.sram_addr[7:0]][15:8] <= bus.sram_dq_out[15:8];
            if (!bus.sram_lb_n) mem[bus.sram_addr[7:0]][7:0]  <= bus.sram_dq_out[7:0];
        end
    end

    always @(negedge Clk) begin
        bus.sram_dq_in <= (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[7:0]] : 16'h0000;
    end

    // ---------------- activity monitors ----------------
    int oe_low     = 0;
    int a_ack_seen = 0;
    int b_ack_seen = 0;

    always @(negedge Clk) begin
        if (bus.sram_oe_n === 1'b0) oe_low     <= oe_low + 1;
        if (bus.a_ack === 1'b1)     a_ack_seen <= a_ack_seen + 1;
        if (bus.b_ack === 1'b1)     b_ack_seen <= b_ack_seen + 1;
    end

    // A request, once raised, must stay up until its ack.
    logic a_pend = 1'b0;
    logic b_pend = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            assert (!(a_pend && !bus.a_req && !bus.a_ack))
                else $error("handshake violation: a_req dropped before a_ack");
            assert (!(b_pend && !bus.b_req && !bus.b_ack))
                else $error("handshake violation: b_req dropped before b_ack");
        end
        if (!Reset || bus.a_ack) a_pend <= 1'b0;
        else if (bus.a_req)      a_pend <= 1'b1;
        if (!Reset || bus.b_ack) b_pend <= 1'b0;
        else if (bus.b_req)      b_pend <= 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.sram_ce_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_oe_n, bus.sram_we_n};
    endfunction

    // Waits (bounded) for the given port's ack; at = -1 on timeout.
    task automatic wait_ack(input logic port_b, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if ((port_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
                at = cyc_cnt;
                break;
            end
        end
    endtask

    // Waits (bounded) for an ack on either port; port_b tells which.
    task automatic wait_any(output logic port_b, output int at);
        at     = -1;
        port_b = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
                at     = cyc_cnt;
                port_b = bus.b_ack;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    bit   pat_b [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
    int   t;
    int   at;
    int   at2;
    int   prev;
    int   snap0;
    int   snap1;
    logic who;

    initial begin
        Reset       = 1'b0;
        bus.a_req   = 1'b0;
        bus.a_we    = 1'b0;
        bus.a_addr  = '0;
        bus.a_be    = 2'b00;
        bus.a_wdata = '0;
        bus.b_req   = 1'b0;
        bus.b_we    = 1'b0;
        bus.b_addr  = '0;
        bus.b_be    = 2'b00;
        bus.b_wdata = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_strobes", strobes(), 5'b11111);
        check("rst_dq_oe", bus.sram_dq_oe, 1'b0);
        check("rst_addr", bus.sram_addr, 20'h0);
        check("rst_dq_out", bus.sram_dq_out, 16'h0);
        check("rst_acks", {bus.a_ack, bus.b_ack}, 2'b00);
        check("rst_rdata", {bus.a_rdata, bus.b_rdata}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // T1: single A read of 0x00010
        snap0 = oe_low;
        snap1 = b_ack_seen;
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 20'h00010; bus.a_be = 2'b11;
        @(negedge Clk);
        check("t1_acc_addr", bus.sram_addr, 20'h00010);
        check("t1_acc_strobes", strobes(), 5'b00001);
        wait_ack(1'b0, at);
        bus.a_req = 1'b0;
        check("t1_latency", at - t, 3);
        check("t1_rdata", bus.a_rdata, 16'hBEEF);
        repeat (2) @(negedge Clk);
        check("t1_oe_cycles", oe_low - snap0, 2);
        check("t1_no_b_ack", b_ack_seen - snap1, 0);
        check("t1_idle_addr", bus.sram_addr, 20'h0);

        // T2: A write 0x1234 to 0x0FFFF, upper byte only
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 20'h0FFFF; bus.a_be = 2'b10;
        bus.a_wdata = 16'h1234;
        @(negedge Clk);
        check("t2_cyc0_strobes", strobes(), 5'b00111);
        check("t2_cyc0_dq", {bus.sram_dq_oe, bus.sram_dq_out}, {1'b1, 16'h1234});
        @(negedge Clk);
        check("t2_cyc1_strobes", strobes(), 5'b00110);
        @(negedge Clk);
        check("t2_done_ack", bus.a_ack, 1'b1);
        check("t2_done_strobes", strobes(), 5'b11111);
        check("t2_done_dq", {bus.sram_dq_oe, bus.sram_dq_out}, {1'b1, 16'h1234});
        bus.a_req = 1'b0;
        @(negedge Clk);
        check("t2_idle_dq_oe", bus.sram_dq_oe, 1'b0);
        check("t2_mem", mem[8'hFF], 16'h12CD);
        check("t2_rdata_held", bus.a_rdata, 16'hBEEF);

        // T3: both ports held; expected grant order B B B A B B B A B
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 20'h00010; bus.a_be = 2'b11;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 20'h00020; bus.b_be = 2'b11;
        prev = t;
        for (int i = 0; i < 9; i++) begin
            wait_any(who, at);
            check($sformatf("t3_port_%0d", i), who, pat_b[i]);
            check($sformatf("t3_spacing_%0d", i), at - prev, (i == 0) ? 3 : 4);
            prev = at;
            if (i == 7) bus.a_req = 1'b0;
            if (i == 8) bus.b_req = 1'b0;
        end
        check("t3_a_rdata", bus.a_rdata, 16'hBEEF);
        check("t3_b_rdata", bus.b_rdata, 16'h5A5A);
        @(negedge Clk);

        // T4: B read in flight, A arrives during B's first ACC cycle
        t = cyc_cnt;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 20'h00021; bus.b_be = 2'b11;
        @(negedge Clk);
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 20'h00002; bus.a_be = 2'b11;
        wait_ack(1'b1, at);
        bus.b_req = 1'b0;
        check("t4_b_latency", at - t, 3);
        check("t4_b_rdata", bus.b_rdata, 16'hC3C3);
        check("t4_a_rdata_untouched", bus.a_rdata, 16'hBEEF);
        wait_ack(1'b0, at2);
        bus.a_req = 1'b0;
        check("t4_a_after_b", at2 - at, 4);
        check("t4_a_rdata", bus.a_rdata, 16'h2222);
        check("t4_b_rdata_held", bus.b_rdata, 16'hC3C3);
        @(negedge Clk);

        // Zero byte enables: access still runs with both lanes disabled
        t = cyc_cnt;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 20'h00040; bus.b_be = 2'b00;
        bus.b_wdata = 16'hFFFF;
        @(negedge Clk);
        check("be0_cyc0_strobes", strobes(), 5'b01111);
        @(negedge Clk);
        check("be0_cyc1_strobes", strobes(), 5'b01110);
        wait_ack(1'b1, at);
        bus.b_req = 1'b0;
        check("be0_latency", at - t, 3);
        @(negedge Clk);
        check("be0_mem", mem[8'h40], 16'h4444);

        // T5: reset during cycle 1 of a write
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 20'h00030; bus.a_be = 2'b11;
        bus.a_wdata = 16'h7777;
        @(negedge Clk);
        @(negedge Clk);
        check("t5_cyc1_strobes", strobes(), 5'b00010);
        Reset = 1'b0;
        bus.a_req = 1'b0;
        bus.a_we  = 1'b0;
        @(negedge Clk);
        check("t5_rst_strobes", strobes(), 5'b11111);
        check("t5_rst_dq_oe", bus.sram_dq_oe, 1'b0);
        check("t5_rst_acks", {bus.a_ack, bus.b_ack}, 2'b00);
        check("t5_rst_addr", bus.sram_addr, 20'h0);
        check("t5_rst_rdata", {bus.a_rdata, bus.b_rdata}, 32'h0);
        Reset = 1'b1;
        snap0 = a_ack_seen;
        repeat (5) @(negedge Clk);
        check("t5_no_ack", a_ack_seen - snap0, 0);
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 20'h00010; bus.a_be = 2'b11;
        wait_ack(1'b0, at);
        bus.a_req = 1'b0;
        check("t5_read_latency", at - t, 3);
        check("t5_read_rdata", bus.a_rdata, 16'hBEEF);
        @(negedge Clk);

        // T6: back-to-back A reads, req held through the first ack
        t = cyc_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 20'h00001; bus.a_be = 2'b11;
        wait_ack(1'b0, at);
        bus.a_addr = 20'h00002;
        check("t6_first_latency", at - t, 3);
        check("t6_first_rdata", bus.a_rdata, 16'h1111);
        wait_ack(1'b0, at2);
        bus.a_req = 1'b0;
        check("t6_spacing", at2 - at, 4);
        check("t6_second_rdata", bus.a_rdata, 16'h2222);
        repeat (2) @(negedge Clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
